// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Contents: loader state enum, default frame start marker, count field width.
// No ports; imported by the loader top module.
package boot_pkg;

  typedef enum logic [2:0] {
    SYNC,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CNT_W         = 16;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host byte stream plus instruction-memory write port of the boot loader.
// master: host/memory side (drives bytes, observes ready and writes).
// slave:  loader side (accepts bytes, drives the write strobe/address/data).
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/boot_word_packer.sv
// Packs accepted data bytes little-endian into 32-bit words and XORs them into a checksum.
// Ports: clk/rst, clr_i (restart), byte_en_i/byte_i (one data byte), word_last_o (4th byte now),
//        word_vld_o (registered one-cycle pulse with word_o valid), csum_o (running XOR).
module boot_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_last_o,
  output logic        word_vld_o,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o
);
  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;
  logic [7:0]  acc_q;
  logic        vld_q;

  assign word_last_o = byte_en_i && (byte_idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      acc_q      <= 8'd0;
      vld_q      <= 1'b0;
    end else begin
      // The pulse lines up with the completed word; the next word's first lane
      // may be overwritten in the same cycle, after the write has sampled it.
      vld_q <= word_last_o;
      if (clr_i) begin
        byte_idx_q <= 2'd0;
        acc_q      <= 8'd0;
      end else if (byte_en_i) begin
        word_q[8*byte_idx_q +: 8] <= byte_i;
        byte_idx_q                <= byte_idx_q + 2'd1;
        acc_q                     <= acc_q ^ byte_i;
      end
    end
  end

  assign word_vld_o = vld_q;
  assign word_o     = word_q;
  assign csum_o     = acc_q;
endmodule

// File: rtl/imem_boot_loader.sv
// Frame parser that loads a program image into instruction memory and releases the core.
// Ports: clk, rst (async active-low), bus (byte stream in, imem write out),
//        reload (restart from DONE), core_rst_n (core held while 0), done, err.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int         ADDR_WIDTH = 10,
  parameter int         MAX_WORDS  = 1024,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus,
  input  logic                reload,
  output logic                core_rst_n,
  output logic                done,
  output logic                err
);
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, word_idx_q, count_full;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ready_q, done_q, err_q, run_q;
  logic                  ready_d, done_d, err_d, run_d;
  logic                  accept, is_sync, data_en, pk_clr;
  logic                  word_last, word_vld;
  logic [31:0]           word;
  logic [7:0]            csum;

  assign accept     = bus.byte_valid && ready_q;
  assign is_sync    = (bus.byte_data == SYNC_BYTE);
  assign data_en    = accept && (state_q == DATA);
  assign count_full = {bus.byte_data, count_q[7:0]};
  // A fresh frame start or a reload restarts byte lanes and checksum.
  assign pk_clr     = (accept && is_sync && (state_q == SYNC || state_q == ERROR)) ||
                      (state_q == DONE && reload);

  boot_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (pk_clr),
    .byte_en_i   (data_en),
    .byte_i      (bus.byte_data),
    .word_last_o (word_last),
    .word_vld_o  (word_vld),
    .word_o      (word),
    .csum_o      (csum)
  );

  // State register plus registered outputs and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SYNC;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
      count_q    <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      run_q   <= run_d;
      if (accept && state_q == LEN0) count_q[7:0] <= bus.byte_data;
      if (accept && state_q == LEN1) count_q      <= count_full;
      if (pk_clr || (accept && state_q == LEN1)) begin
        word_idx_q <= '0;
      end else if (word_last) begin
        word_idx_q <= word_idx_q + ONE;
        addr_q     <= word_idx_q[ADDR_WIDTH-1:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:  if (accept && is_sync) state_d = LEN0;
      LEN0:  if (accept) state_d = LEN1;
      LEN1: begin
        if (accept) begin
          if (count_full > MAX_N)       state_d = ERROR;
          else if (count_full == '0)    state_d = CSUM;
          else                          state_d = DATA;
        end
      end
      DATA:  if (word_last && (word_idx_q == count_q - ONE)) state_d = CSUM;
      CSUM:  if (accept) state_d = (bus.byte_data == csum) ? DONE : ERROR;
      DONE:  if (reload) state_d = SYNC;
      ERROR: if (accept && is_sync) state_d = LEN0;
      default: state_d = SYNC;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state they describe.
  always_comb begin
    ready_d = (state_d != DONE);
    done_d  = (state_d == DONE);
    run_d   = (state_d == DONE);
    err_d   = (state_d == ERROR);
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = word_vld;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign core_rst_n     = run_q;
  assign done           = done_q;
  assign err            = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: frames are built from word lists, expected
// writes are queued at build time and a negedge monitor checks every imem_we pulse.
module tb_imem_boot_loader;
  import boot_pkg::*;

  localparam int AW   = 10;
  localparam int MAXW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reload = 1'b0;
  logic core_rst_n, done, err;

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus();

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .SYNC_BYTE(SYNC_BYTE_DEF)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .reload     (reload),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  logic [7:0] nominal [12] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50,
                               8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe cycle must match the oldest queued expectation.
  wr_t got;
  always @(negedge clk) begin
    if (rst && bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", bus.imem_addr, bus.imem_wdata);
      end else begin
        got = exp_q.pop_front();
        check("imem_addr", 32'(bus.imem_addr), 32'(got.addr));
        check("imem_wdata", bus.imem_wdata, got.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_ready_timeout: byte %h not accepted within 50 cycles", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$], input int gap_pct);
    foreach (q[i]) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send_byte(q[i]);
    end
    idle();
  endtask

  task automatic push_nominal_exp();
    exp_q.push_back('{addr: 10'd0, data: 32'h0050_0093});
    exp_q.push_back('{addr: 10'd1, data: 32'h00A0_0113});
  endtask

  task automatic settle_and_status(input string tag, input bit ok);
    repeat (4) @(negedge clk);
    check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({tag, "_done"},       32'(done),           32'(ok));
    check({tag, "_err"},        32'(err),            32'(!ok));
    check({tag, "_core_rst_n"}, 32'(core_rst_n),     32'(ok));
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'(!ok));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
    check({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n),     32'd0);
    check({tag, "_done"},       32'(done),           32'd0);
    check({tag, "_err"},        32'(err),            32'd0);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
  endtask

  task automatic pulse_reload(input string tag);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check({tag, "_core_rst_n"}, 32'(core_rst_n),     32'd0);
    check({tag, "_done"},       32'(done),           32'd0);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd1);
    check({tag, "_err"},        32'(err),            32'd0);
  endtask

  // Reference frame: bytes and expected writes both derived from a random word list.
  task automatic random_frame(input int n, input bit bad, input int junk, input int gap_pct);
    logic [7:0]  q[$];
    logic [7:0]  cs = 8'd0;
    logic [7:0]  jb;
    logic [31:0] w;
    logic [15:0] n16 = 16'(n);
    for (int j = 0; j < junk; j++) begin
      jb = 8'($urandom_range(0, 255));
      q.push_back((jb == SYNC_BYTE_DEF) ? 8'h00 : jb);
    end
    q.push_back(SYNC_BYTE_DEF);
    q.push_back(n16[7:0]);
    q.push_back(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) begin
        q.push_back(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
      exp_q.push_back('{addr: AW'(i), data: w});
    end
    q.push_back(bad ? (cs ^ 8'h5C) : cs);
    send_q(q, gap_pct);
  endtask

  initial begin
    logic [7:0] q[$];
    bit bad;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state
    #1 rst = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.byte_ready), 32'd1);

    // Reload outside DONE does nothing
    pulse_reload("reload_in_sync");

    // Nominal load, bytes back-to-back
    push_nominal_exp();
    q.delete();
    foreach (nominal[i]) q.push_back(nominal[i]);
    send_q(q, 0);
    settle_and_status("nominal", 1'b1);
    pulse_reload("reload_in_done");

    // Bad checksum, then recovery with a good frame
    push_nominal_exp();
    q[11] = 8'h70;
    send_q(q, 0);
    settle_and_status("bad_csum", 1'b0);
    random_frame(3, 1'b0, 0, 30);
    settle_and_status("recover", 1'b1);
    pulse_reload("reload2");

    // Oversize image: error straight after the count, no writes
    q.delete();
    q.push_back(8'hA5); q.push_back(8'h01); q.push_back(8'h04);
    send_q(q, 0);
    settle_and_status("oversize", 1'b0);

    // Empty image
    q.delete();
    q.push_back(8'hA5); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00);
    send_q(q, 0);
    settle_and_status("empty", 1'b1);
    pulse_reload("reload3");

    // Junk bytes ahead of the nominal frame, valid held every cycle
    push_nominal_exp();
    q.delete();
    q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h5A);
    foreach (nominal[i]) q.push_back(nominal[i]);
    send_q(q, 0);
    settle_and_status("junk", 1'b1);
    pulse_reload("reload4");

    // Reset after the 6th byte of a frame
    for (int i = 0; i < 6; i++) send_byte(nominal[i]);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    push_nominal_exp();
    q.delete();
    foreach (nominal[i]) q.push_back(nominal[i]);
    send_q(q, 10);
    settle_and_status("after_reset", 1'b1);
    pulse_reload("reload5");

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      bad = ($urandom_range(0, 3) == 0);
      random_frame($urandom_range(1, 8), bad, $urandom_range(0, 2), $urandom_range(0, 50));
      settle_and_status("random", !bad);
      if (!bad) pulse_reload("reload_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
